// File: rtl/sudoku_grid_loader_if.sv
// Puzzle byte stream in, initial grid and load status out.
interface sudoku_grid_loader_if;
    logic              i_Valid;
    logic [7:0]        i_Byte;
    logic              o_Ready;
    logic              i_Consume;
    logic [80:0][8:0]  o_Grid;
    logic              o_GridValid;
    logic [6:0]        o_Givens;
    logic              o_Error;
    logic [1:0]        o_ErrCode;
    logic [6:0]        o_CellIdx;

    modport master (
        output i_Valid, i_Byte, i_Consume,
        input  o_Ready, o_Grid, o_GridValid, o_Givens, o_Error, o_ErrCode, o_CellIdx
    );
    modport slave (
        input  i_Valid, i_Byte, i_Consume,
        output o_Ready, o_Grid, o_GridValid, o_Givens, o_Error, o_ErrCode, o_CellIdx
    );
endinterface

// File: rtl/sudoku_grid_loader.sv
// Converts an ASCII puzzle stream into a one-hot 81-cell grid, rejecting
// illegal characters and givens that clash with their row, column or box.
module sudoku_grid_loader #(
    parameter bit ALLOW_DOT   = 1'b1,
    parameter bit CHECK_DUPES = 1'b1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    sudoku_grid_loader_if.slave  bus
);
    typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic [80:0][8:0]  grid;
    logic [8:0][8:0]   row_used, col_used, box_used;
    logic [3:0]        r, c, box;
    logic [1:0]        rsub, csub, br, bc;
    logic [6:0]        idx, givens;
    logic [1:0]        err_code;

    logic              is_digit, is_blank, is_ws, accept, bad_char, dup, cell_ok;
    logic [8:0]        onehot;

    // Box number from the 0..2 box-row/box-column counters; no division needed.
    assign box = 4'(br) * 4'd3 + 4'(bc);

    always_comb begin
        is_digit = (bus.i_Byte >= 8'h31) && (bus.i_Byte <= 8'h39);
        is_blank = (bus.i_Byte == 8'h30) || (ALLOW_DOT && (bus.i_Byte == 8'h2E));
        is_ws    = (bus.i_Byte == 8'h20) || (bus.i_Byte == 8'h09) ||
                   (bus.i_Byte == 8'h0A) || (bus.i_Byte == 8'h0D);
        onehot   = is_digit ? (9'd1 << (bus.i_Byte[3:0] - 4'd1)) : 9'd0;
        dup      = CHECK_DUPES && is_digit &&
                   (|(onehot & (row_used[r] | col_used[c] | box_used[box])));
        accept   = (state == LOAD) && bus.i_Valid;
        bad_char = accept && !(is_digit || is_blank || is_ws);
        cell_ok  = accept && (is_digit || is_blank) && !dup;
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_Consume)
            state_nxt = LOAD;
        else if (bad_char || (accept && dup))
            state_nxt = ERR;
        else if (cell_ok && (idx == 7'd80))
            state_nxt = DONE;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= LOAD;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            grid     <= '0;
            row_used <= '0;
            col_used <= '0;
            box_used <= '0;
            r        <= '0;
            c        <= '0;
            rsub     <= '0;
            csub     <= '0;
            br       <= '0;
            bc       <= '0;
            idx      <= '0;
            givens   <= '0;
            err_code <= '0;
        end else if (bus.i_Consume) begin
            // Consume wins over a coincident byte, which is simply dropped.
            grid     <= '0;
            row_used <= '0;
            col_used <= '0;
            box_used <= '0;
            r        <= '0;
            c        <= '0;
            rsub     <= '0;
            csub     <= '0;
            br       <= '0;
            bc       <= '0;
            idx      <= '0;
            givens   <= '0;
            err_code <= '0;
        end else begin
            if (bad_char)          err_code <= 2'd1;
            else if (accept && dup) err_code <= 2'd2;

            if (cell_ok) begin
                grid[idx]     <= onehot;
                row_used[r]   <= row_used[r] | onehot;
                col_used[c]   <= col_used[c] | onehot;
                box_used[box] <= box_used[box] | onehot;
                givens        <= givens + 7'(is_digit);
                idx           <= idx + 7'd1;
                if (c == 4'd8) begin
                    c    <= '0;
                    csub <= '0;
                    bc   <= '0;
                    r    <= r + 4'd1;
                    if (rsub == 2'd2) begin
                        rsub <= '0;
                        br   <= br + 2'd1;
                    end else begin
                        rsub <= rsub + 2'd1;
                    end
                end else begin
                    c <= c + 4'd1;
                    if (csub == 2'd2) begin
                        csub <= '0;
                        bc   <= bc + 2'd1;
                    end else begin
                        csub <= csub + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.o_Ready     = (state == LOAD);
    assign bus.o_GridValid = (state == DONE);
    assign bus.o_Error     = (state == ERR);
    assign bus.o_ErrCode   = err_code;
    assign bus.o_CellIdx   = idx;
    assign bus.o_Givens    = givens;
    assign bus.o_Grid      = grid;
endmodule
